hazard_unit: RTL and testbench
==============================

// Module: hazard_unit
// PURPOSE
//  Hazard detection and stall/flush control for the 5-stage MIPS pipeline. Sits beside forwarding_unit
//  and covers the hazards forwarding cannot resolve: load-use, branch-in-ID dependences, and the
//  multi-cycle mult/div unit. Drives PC/IF-ID write-enables, the ID/EX bubble and the IF/ID flush.
// PARAMETERS
//  MD_LATENCY  4   cycles mult/div is busy after launch (>=2); HI/LO valid on cycle MD_LATENCY
//  STAT_W      32  width of statistics counters (HAZARD_STATS_EN only)
// PORTS
//  clk            in   1  pipeline clock, all state on rising edge
//  rst_n          in   1  reset; asynchronous, active-low
//  D_rs, D_rt     in   5  source regs of instruction in ID
//  D_usesRt       in   1  ID instruction reads rt as a source
//  D_isBranch     in   1  ID instruction is beq/bne (compared in ID)
//  D_branchTaken  in   1  ID branch comparison result (after ID forwarding)
//  D_mdOp         in   1  ID instruction is mult/div
//  D_readsHiLo    in   1  ID instruction is mfhi/mflo
//  X_writeReg     in   5  dest reg of instruction in EX
//  X_regWrite     in   1  EX instruction writes register file
//  X_memRead      in   1  EX instruction is a load
//  X_mdStart      in   1  EX instruction launches mult/div this cycle
//  M_writeReg     in   5  dest reg of instruction in MEM
//  M_memRead      in   1  MEM instruction is a load
//  stall_F        out  1  hold PC
//  stall_D        out  1  hold IF/ID
//  flush_X        out  1  load bubble (zero control) into ID/EX
//  flush_D        out  1  clear IF/ID (taken branch)
//  md_busy        out  1  mult/div in flight
//  stat_stalls    out  STAT_W  stall-cycle count
//  stat_flushes   out  STAT_W  branch-flush count
// BEHAVIOUR
//  - Matches ignore reg 0. src_hit(r) = r==D_rs || (D_usesRt && r==D_rt).
//  - load_use  = X_memRead && src_hit(X_writeReg).
//  - br_haz    = D_isBranch && ((X_regWrite && src_hit(X_writeReg)) || (M_memRead && src_hit(M_writeReg))).
//    Branch after load therefore stalls 2 cycles (EX then MEM); after ALU op, 1 cycle.
//  - md FSM: IDLE --X_mdStart--> BUSY, cnt=MD_LATENCY-1; BUSY: cnt-- each cycle; cnt==1 -> IDLE.
//    X_mdStart while BUSY cannot occur (blocked below); if it does, it is ignored.
//  - md_haz = md_busy && (D_mdOp || D_readsHiLo); md_busy = (state==BUSY).
//  - stall = load_use | br_haz | md_haz; stall_F = stall_D = flush_X = stall (combinational, same cycle).
//  - flush_D = D_isBranch && D_branchTaken && !stall (branch resolves only when not stalled).
//  - Reset: state IDLE, cnt 0, stats 0; with no hazard inputs all outputs are 0. Reset mid-BUSY
//    aborts the op immediately; md_busy drops asynchronously.
// CONFIGURATION
//  HAZARD_STATS_EN defined: stat_stalls += 1 each stall cycle, stat_flushes += 1 each flush_D cycle;
//   both saturate at all-ones. Undefined: no counters built, stat_* tied to 0, ports retained.
// STRUCTURE
//  hazard_pkg: REG_W=5, REG_ZERO, md_state_t {MD_IDLE, MD_BUSY}, function src_hit.
//  Sub-module md_busy_tracker (FSM + down-counter, outputs md_busy); rest is inline.
// TESTING
//  1 lw $2 in EX, D_rs=2 -> stall_F/stall_D/flush_X=1 one cycle; next cycle (lw in MEM) 0.
//  2 beq D_rs=3, lw $3 in EX -> stall 2 consecutive cycles, then flush_D=1 if taken.
//  3 beq D_rt=4 with D_usesRt=1, add $4 in EX -> 1 stall; D_rt=0 with $0 dest -> no stall.
//  4 X_mdStart, then mfhi in ID, MD_LATENCY=4 -> stall 3 cycles, md_busy 3 cycles, then release.
//  5 Taken branch with simultaneous br_haz -> flush_D=0 while stalled, 1 on first non-stall cycle.
//  6 rst_n low mid-BUSY -> md_busy=0 immediately; stat_* =0 (HAZARD_STATS_EN); counters saturate.

Source files
------------

// File: rtl/hazard_pkg.sv
// rtl/hazard_pkg.sv - shared types and helpers for the pipeline hazard unit
// Contents: REG_W / REG_ZERO register-index constants, md_state_t for the
// mult/div tracker, and src_hit() which matches a destination register
// against the sources of the instruction in ID ($0 never matches).
package hazard_pkg;

  localparam int REG_W = 5;
  localparam logic [REG_W-1:0] REG_ZERO = '0;

  typedef enum logic {
    MD_IDLE = 1'b0,
    MD_BUSY = 1'b1
  } md_state_t;

  // True when r is a real (non-$0) register read by the ID instruction.
  function automatic logic src_hit(input logic [REG_W-1:0] r,
                                   input logic [REG_W-1:0] rs,
                                   input logic [REG_W-1:0] rt,
                                   input logic             uses_rt);
    return (r != REG_ZERO) && ((r == rs) || (uses_rt && (r == rt)));
  endfunction

endpackage

// File: rtl/md_busy_tracker.sv
// rtl/md_busy_tracker.sv - tracks the in-flight window of the multi-cycle mult/div unit
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset
//   start        mult/div launches from EX this cycle
//   md_busy      high for MD_LATENCY-1 cycles after the launch cycle
// A start seen while already busy is ignored (the ID stall prevents it).
module md_busy_tracker
  import hazard_pkg::*;
#(
  parameter int MD_LATENCY = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic start,
  output logic md_busy
);

  localparam int CNT_W = $clog2(MD_LATENCY + 1);

  md_state_t        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= MD_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      MD_IDLE: begin
        if (start) begin
          state_d = MD_BUSY;
          cnt_d   = CNT_W'(MD_LATENCY - 1);
        end
      end
      MD_BUSY: begin
        // Last busy cycle when cnt reaches 1; HI/LO readable next cycle.
        if (cnt_q == CNT_W'(1)) begin
          state_d = MD_IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default: begin
        state_d = MD_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  assign md_busy = (state_q == MD_BUSY);

endmodule

// File: rtl/hazard_unit.sv
// rtl/hazard_unit.sv - load-use, branch-in-ID and mult/div hazard detection with stall/flush control
// Optional feature macro: HAZARD_STATS_EN (saturating stall/flush counters;
// when undefined stat_* are tied to 0).
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   D_rs, D_rt, D_usesRt       sources of the ID instruction
//   D_isBranch, D_branchTaken  ID branch and its resolved outcome
//   D_mdOp, D_readsHiLo        ID instruction needs the mult/div unit / HI-LO
//   X_writeReg, X_regWrite, X_memRead, X_mdStart   EX instruction info
//   M_writeReg, M_memRead      MEM instruction info
//   stall_F, stall_D, flush_X  hold PC, hold IF/ID, bubble into ID/EX
//   flush_D                    clear IF/ID on a resolved taken branch
//   md_busy                    mult/div in flight
//   stat_stalls, stat_flushes  statistics counters
module hazard_unit
  import hazard_pkg::*;
#(
  parameter int MD_LATENCY = 4,
  parameter int STAT_W     = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [REG_W-1:0]  D_rs,
  input  logic [REG_W-1:0]  D_rt,
  input  logic              D_usesRt,
  input  logic              D_isBranch,
  input  logic              D_branchTaken,
  input  logic              D_mdOp,
  input  logic              D_readsHiLo,
  input  logic [REG_W-1:0]  X_writeReg,
  input  logic              X_regWrite,
  input  logic              X_memRead,
  input  logic              X_mdStart,
  input  logic [REG_W-1:0]  M_writeReg,
  input  logic              M_memRead,
  output logic              stall_F,
  output logic              stall_D,
  output logic              flush_X,
  output logic              flush_D,
  output logic              md_busy,
  output logic [STAT_W-1:0] stat_stalls,
  output logic [STAT_W-1:0] stat_flushes
);

  logic x_hit, m_hit;
  logic load_use, br_haz, md_haz, stall;

  md_busy_tracker #(
    .MD_LATENCY(MD_LATENCY)
  ) u_md (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (X_mdStart),
    .md_busy(md_busy)
  );

  assign x_hit = src_hit(X_writeReg, D_rs, D_rt, D_usesRt);
  assign m_hit = src_hit(M_writeReg, D_rs, D_rt, D_usesRt);

  assign load_use = X_memRead && x_hit;
  // Branches compare in ID, so even an ALU result in EX is too late; a load
  // result is still too late while the load sits in MEM.
  assign br_haz   = D_isBranch && ((X_regWrite && x_hit) || (M_memRead && m_hit));
  assign md_haz   = md_busy && (D_mdOp || D_readsHiLo);
  assign stall    = load_use | br_haz | md_haz;

  assign stall_F = stall;
  assign stall_D = stall;
  assign flush_X = stall;
  // A stalled branch has not resolved yet; it flushes on its first free cycle.
  assign flush_D = D_isBranch && D_branchTaken && !stall;

`ifdef HAZARD_STATS_EN
  logic [STAT_W-1:0] stalls_q, flushes_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stalls_q  <= '0;
      flushes_q <= '0;
    end else begin
      if (stall && (stalls_q != '1))
        stalls_q <= stalls_q + STAT_W'(1);
      if (flush_D && (flushes_q != '1))
        flushes_q <= flushes_q + STAT_W'(1);
    end
  end

  assign stat_stalls  = stalls_q;
  assign stat_flushes = flushes_q;
`else
  assign stat_stalls  = '0;
  assign stat_flushes = '0;
`endif

endmodule

// File: tb/tb_hazard_unit.sv
// tb/tb_hazard_unit.sv - scoreboard bench for hazard_unit with directed per-cycle vectors
module tb_hazard_unit;

  localparam int STAT_W = 4;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [4:0]        D_rs = '0, D_rt = '0, X_writeReg = '0, M_writeReg = '0;
  logic              D_usesRt = 0, D_isBranch = 0, D_branchTaken = 0, D_mdOp = 0;
  logic              D_readsHiLo = 0, X_regWrite = 0, X_memRead = 0, X_mdStart = 0, M_memRead = 0;
  logic              stall_F, stall_D, flush_X, flush_D, md_busy;
  logic [STAT_W-1:0] stat_stalls, stat_flushes;

  hazard_unit #(.MD_LATENCY(4), .STAT_W(STAT_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .D_rs(D_rs), .D_rt(D_rt), .D_usesRt(D_usesRt), .D_isBranch(D_isBranch),
    .D_branchTaken(D_branchTaken), .D_mdOp(D_mdOp), .D_readsHiLo(D_readsHiLo),
    .X_writeReg(X_writeReg), .X_regWrite(X_regWrite), .X_memRead(X_memRead),
    .X_mdStart(X_mdStart), .M_writeReg(M_writeReg), .M_memRead(M_memRead),
    .stall_F(stall_F), .stall_D(stall_D), .flush_X(flush_X), .flush_D(flush_D),
    .md_busy(md_busy), .stat_stalls(stat_stalls), .stat_flushes(stat_flushes)
  );

  always #5 clk = ~clk;

  typedef struct {
    int                id;
    logic              stall;
    logic              flush_d;
    logic              busy;
    logic [STAT_W-1:0] ss;
    logic [STAT_W-1:0] sf;
  } exp_t;

  exp_t exp_q[$];
  int   vectors = 0;
  int   miscompares = 0;
  int   vec_id = 0;
  logic [STAT_W-1:0] m_stalls = '0, m_flushes = '0;

  task automatic chk(input int id, input string nm, input logic [31:0] act, input logic [31:0] req);
    if (act !== req) begin
      miscompares++;
      $display("FAIL vec %0d %s: got %0h expected %0h", id, nm, act, req);
    end
  endtask

  // Monitor: one expected entry per cycle, compared mid-cycle.
  always @(negedge clk) begin
    if (exp_q.size() != 0) begin
      exp_t e;
      e = exp_q.pop_front();
      vectors++;
      chk(e.id, "stall_F", 32'(stall_F), 32'(e.stall));
      chk(e.id, "stall_D", 32'(stall_D), 32'(e.stall));
      chk(e.id, "flush_X", 32'(flush_X), 32'(e.stall));
      chk(e.id, "flush_D", 32'(flush_D), 32'(e.flush_d));
      chk(e.id, "md_busy", 32'(md_busy), 32'(e.busy));
      chk(e.id, "stat_stalls", 32'(stat_stalls), 32'(e.ss));
      chk(e.id, "stat_flushes", 32'(stat_flushes), 32'(e.sf));
    end
  end

  // Driver: apply one cycle of inputs and push its hand-computed response.
  task automatic step(input logic rst, input logic [4:0] rs, input logic [4:0] rt,
                      input logic ur, input logic br, input logic tk,
                      input logic mdop, input logic hl,
                      input logic [4:0] xw, input logic xrw, input logic xmr, input logic xms,
                      input logic [4:0] mw, input logic mmr,
                      input logic es, input logic ef, input logic eb);
    exp_t e;
    @(posedge clk);
    #1;
    rst_n = rst; D_rs = rs; D_rt = rt; D_usesRt = ur; D_isBranch = br;
    D_branchTaken = tk; D_mdOp = mdop; D_readsHiLo = hl;
    X_writeReg = xw; X_regWrite = xrw; X_memRead = xmr; X_mdStart = xms;
    M_writeReg = mw; M_memRead = mmr;
    if (!rst) begin
      m_stalls  = '0;
      m_flushes = '0;
    end
    e.id = vec_id; e.stall = es; e.flush_d = ef; e.busy = eb;
`ifdef HAZARD_STATS_EN
    e.ss = m_stalls; e.sf = m_flushes;
`else
    e.ss = '0; e.sf = '0;
`endif
    exp_q.push_back(e);
    vec_id++;
    if (rst) begin
      if (es && (m_stalls != '1))  m_stalls++;
      if (ef && (m_flushes != '1)) m_flushes++;
    end
  endtask

  initial begin
    int waited;
    //   rst rs rt ur br tk md hl  xw xrw xmr xms mw mmr  stall flushD busy
    step(0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0,  0, 0,    0, 0, 0); // in reset
    step(1, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0,  0, 0,    0, 0, 0); // idle
    // load-use on rs, then the load moves to MEM
    step(1, 2, 0, 0, 0, 0, 0, 0,  2, 1, 1, 0,  0, 0,    1, 0, 0);
    step(1, 2, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0,  2, 1,    0, 0, 0);
    // load to rt that ID does not read: no stall
    step(1, 5, 2, 0, 0, 0, 0, 0,  2, 1, 1, 0,  0, 0,    0, 0, 0);
    // load to $0: no stall
    step(1, 0, 0, 1, 0, 0, 0, 0,  0, 1, 1, 0,  0, 0,    0, 0, 0);
    // taken beq after lw $3: stall in EX, stall in MEM, then flush
    step(1, 3, 0, 0, 1, 1, 0, 0,  3, 1, 1, 0,  0, 0,    1, 0, 0);
    step(1, 3, 0, 0, 1, 1, 0, 0,  0, 0, 0, 0,  3, 1,    1, 0, 0);
    step(1, 3, 0, 0, 1, 1, 0, 0,  0, 0, 0, 0,  0, 0,    0, 1, 0);
    // beq rt=4 after add $4: one stall, then resolves not taken
    step(1, 1, 4, 1, 1, 0, 0, 0,  4, 1, 0, 0,  0, 0,    1, 0, 0);
    step(1, 1, 4, 1, 1, 0, 0, 0,  0, 0, 0, 0,  4, 0,    0, 0, 0);
    // beq rt=0 with $0 destination: no stall
    step(1, 6, 0, 1, 1, 0, 0, 0,  0, 1, 0, 0,  0, 0,    0, 0, 0);
    // taken beq after ALU op: flush held off while stalled
    step(1, 7, 0, 0, 1, 1, 0, 0,  7, 1, 0, 0,  0, 0,    1, 0, 0);
    step(1, 7, 0, 0, 1, 1, 0, 0,  0, 0, 0, 0,  7, 0,    0, 1, 0);
    // mult launch, mfhi waits 3 busy cycles; a second start mid-busy is ignored
    step(1, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 1,  0, 0,    0, 0, 0);
    step(1, 0, 0, 0, 0, 0, 0, 1,  0, 0, 0, 0,  0, 0,    1, 0, 1);
    step(1, 0, 0, 0, 0, 0, 0, 1,  0, 0, 0, 1,  0, 0,    1, 0, 1);
    step(1, 0, 0, 0, 0, 0, 1, 0,  0, 0, 0, 0,  0, 0,    1, 0, 1);
    step(1, 0, 0, 0, 0, 0, 0, 1,  0, 0, 0, 0,  0, 0,    0, 0, 0);
    // busy but ID does not need mult/div: no stall
    step(1, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 1,  0, 0,    0, 0, 0);
    step(1, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0,  0, 0,    0, 0, 1);
    // reset mid-busy drops md_busy within the same cycle
    step(0, 0, 0, 0, 0, 0, 0, 1,  0, 0, 0, 0,  0, 0,    0, 0, 0);
    step(1, 0, 0, 0, 0, 0, 0, 1,  0, 0, 0, 0,  0, 0,    0, 0, 0);
    // drive counters into saturation
    for (int i = 0; i < 18; i++)
      step(1, 9, 0, 0, 0, 0, 0, 0,  9, 1, 1, 0,  0, 0,  1, 0, 0);
    for (int i = 0; i < 17; i++)
      step(1, 1, 0, 0, 1, 1, 0, 0,  0, 0, 0, 0,  0, 0,  0, 1, 0);
    step(1, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0,  0, 0,    0, 0, 0);
    // reset clears saturated counters
    step(0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0,  0, 0,    0, 0, 0);
    step(1, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0,  0, 0,    0, 0, 0);

    waited = 0;
    while (exp_q.size() != 0 && waited < 10) begin
      @(posedge clk);
      waited++;
    end
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL drain: %0d entries left, expected 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
